// File: rtl/ps2_dir_keys_if.sv
// Decoded key bus from the PS/2 receiver to the player movement stage.
// The master drives the held levels and the per-code event signals; the slave consumes them.
interface ps2_dir_keys_if;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       enter;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       frame_err;

    modport master (
        output up, down, left, right, enter,
        output key_valid, key_code, key_ext, key_break, frame_err
    );

    modport slave (
        input up, down, left, right, enter,
        input key_valid, key_code, key_ext, key_break, frame_err
    );
endinterface

// File: rtl/ps2_dir_keys.sv
// PS/2 keyboard receiver and scan-code decoder producing held direction/enter levels.
// Optional build macro PS2_WASD_EN adds W/A/S/D as a second source for the directions.
module ps2_dir_keys #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    ps2_dir_keys_if.master keys
);

    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Direction bit order: 0 up, 1 down, 2 left, 3 right.
    localparam int unsigned D_UP    = 0;
    localparam int unsigned D_DOWN  = 1;
    localparam int unsigned D_LEFT  = 2;
    localparam int unsigned D_RIGHT = 3;

    logic           clk_s1, clk_s2, dat_s1, dat_s2;
    logic           filt_lvl;
    logic [FCW-1:0] filt_cnt;
    logic           fall;

    state_t         state, state_n;
    logic [7:0]     shift, shift_n;
    logic [2:0]     bit_cnt, bit_cnt_n;
    logic           par_bit, par_n;
    logic [TCW-1:0] tmo_cnt;
    logic           timeout_c, good_c, err_c;

    logic           ext_f, ext_n, brk_f, brk_n;
    logic [3:0]     arr_q, arr_n;
    logic           enter_q, enter_n;
    logic           kv_c;
`ifdef PS2_WASD_EN
    logic [3:0]     wasd_q, wasd_n;
`endif

    // Two-flop synchronizers; pins idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Glitch filter on the keyboard clock; fall strobes on the accepted 1->0 change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_lvl <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s2 != filt_lvl) begin
                if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                    filt_lvl <= clk_s2;
                    filt_cnt <= '0;
                    fall     <= filt_lvl;
                end else begin
                    filt_cnt <= filt_cnt + FCW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_cnt <= bit_cnt_n;
            par_bit <= par_n;
        end
    end

    // Inactivity timer for an in-progress frame; any accepted fall restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == S_IDLE || fall) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TCW'(1);
        end
    end

    assign timeout_c = (state != S_IDLE) && !fall && (tmo_cnt == TCW'(TIMEOUT_CYCLES - 1));

    // Frame FSM: start, 8 data bits LSB-first, odd parity, stop.
    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_cnt_n = bit_cnt;
        par_n     = par_bit;
        good_c    = 1'b0;
        err_c     = 1'b0;
        if (timeout_c) begin
            state_n = S_IDLE;
            err_c   = 1'b1;
        end else if (fall) begin
            unique case (state)
                S_IDLE: begin
                    if (!dat_s2) begin
                        state_n   = S_DATA;
                        bit_cnt_n = '0;
                    end else begin
                        err_c = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_n   = {dat_s2, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = S_PARITY;
                end
                S_PARITY: begin
                    par_n   = dat_s2;
                    state_n = S_STOP;
                end
                S_STOP: begin
                    state_n = S_IDLE;
                    if (dat_s2 && (^{shift, par_bit})) good_c = 1'b1;
                    else                               err_c  = 1'b1;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Scan-code decoder: prefix tracking and held-level updates.
    always_comb begin
        ext_n   = ext_f;
        brk_n   = brk_f;
        arr_n   = arr_q;
        enter_n = enter_q;
        kv_c    = 1'b0;
`ifdef PS2_WASD_EN
        wasd_n  = wasd_q;
`endif
        if (err_c) begin
            ext_n = 1'b0;
            brk_n = 1'b0;
        end else if (good_c) begin
            if (shift == 8'hE0) begin
                ext_n = 1'b1;
            end else if (shift == 8'hF0) begin
                brk_n = 1'b1;
            end else begin
                kv_c  = 1'b1;
                ext_n = 1'b0;
                brk_n = 1'b0;
                if (ext_f) begin
                    case (shift)
                        8'h75:   arr_n[D_UP]    = !brk_f;
                        8'h72:   arr_n[D_DOWN]  = !brk_f;
                        8'h6B:   arr_n[D_LEFT]  = !brk_f;
                        8'h74:   arr_n[D_RIGHT] = !brk_f;
                        default: ;
                    endcase
                end else begin
                    case (shift)
                        8'h5A:   enter_n        = !brk_f;
`ifdef PS2_WASD_EN
                        8'h1D:   wasd_n[D_UP]    = !brk_f;
                        8'h1B:   wasd_n[D_DOWN]  = !brk_f;
                        8'h1C:   wasd_n[D_LEFT]  = !brk_f;
                        8'h23:   wasd_n[D_RIGHT] = !brk_f;
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_f          <= 1'b0;
            brk_f          <= 1'b0;
            arr_q          <= '0;
            enter_q        <= 1'b0;
`ifdef PS2_WASD_EN
            wasd_q         <= '0;
`endif
            keys.up        <= 1'b0;
            keys.down      <= 1'b0;
            keys.left      <= 1'b0;
            keys.right     <= 1'b0;
            keys.enter     <= 1'b0;
            keys.key_valid <= 1'b0;
            keys.key_code  <= 8'h00;
            keys.key_ext   <= 1'b0;
            keys.key_break <= 1'b0;
            keys.frame_err <= 1'b0;
        end else begin
            ext_f          <= ext_n;
            brk_f          <= brk_n;
            arr_q          <= arr_n;
            enter_q        <= enter_n;
            keys.enter     <= enter_n;
            keys.key_valid <= kv_c;
            keys.frame_err <= err_c;
`ifdef PS2_WASD_EN
            wasd_q         <= wasd_n;
            keys.up        <= arr_n[D_UP]    | wasd_n[D_UP];
            keys.down      <= arr_n[D_DOWN]  | wasd_n[D_DOWN];
            keys.left      <= arr_n[D_LEFT]  | wasd_n[D_LEFT];
            keys.right     <= arr_n[D_RIGHT] | wasd_n[D_RIGHT];
`else
            keys.up        <= arr_n[D_UP];
            keys.down      <= arr_n[D_DOWN];
            keys.left      <= arr_n[D_LEFT];
            keys.right     <= arr_n[D_RIGHT];
`endif
            if (kv_c) begin
                keys.key_code  <= shift;
                keys.key_ext   <= ext_f;
                keys.key_break <= brk_f;
            end
        end
    end

endmodule

// File: tb/tb_ps2_dir_keys.sv
// Directed bench for ps2_dir_keys: bit-level PS/2 frames, scoreboard of expected
// key/error events checked by a monitor, plus held-level checks after each step.
module tb_ps2_dir_keys;

    localparam int unsigned FILTER_LEN     = 4;
    localparam int unsigned TIMEOUT_CYCLES = 50000;
    localparam int          HALF           = 20;

    typedef struct {
        logic       is_err;
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic ps2_clk;
    logic ps2_data;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_fall = 0;
    ev_t  exp_q[$];

    ps2_dir_keys_if keys();

    ps2_dir_keys #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .keys    (keys.master)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Monitor: every key_valid / frame_err pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && (keys.key_valid || keys.frame_err)) begin
            chk("pulse_exclusive", 32'(keys.key_valid & keys.frame_err), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'({keys.key_valid, keys.frame_err}), 32'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("event_kind", 32'(keys.frame_err), 32'(e.is_err));
                if (!e.is_err) begin
                    chk("event_code", 32'({keys.key_ext, keys.key_break, keys.key_code}),
                        32'({e.ext, e.brk, e.code}));
                end
            end
        end
    end

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        ps2_clk   = 1'b0;
        last_fall = cyc;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    task automatic push_ev(input logic is_err, input logic [7:0] code, input logic ext, input logic brk);
        ev_t e;
        e.is_err = is_err;
        e.code   = code;
        e.ext    = ext;
        e.brk    = brk;
        exp_q.push_back(e);
    endtask

    task automatic send_key(input logic [7:0] code, input logic ext, input logic brk);
        if (ext) send_byte(8'hE0, 1'b0);
        if (brk) send_byte(8'hF0, 1'b0);
        push_ev(1'b0, code, ext, brk);
        send_byte(code, 1'b0);
    endtask

    task automatic chk_dirs(input string tag, input logic [4:0] exp_v);
        @(negedge clk);
        chk(tag, 32'({keys.up, keys.down, keys.left, keys.right, keys.enter}), 32'(exp_v));
    endtask

    initial begin
        int  err_cyc;
        bit  got;
        int  d;
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({keys.up, keys.down, keys.left, keys.right, keys.enter,
                                  keys.key_valid, keys.key_code, keys.key_ext,
                                  keys.key_break, keys.frame_err}), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // Non-extended 75 is not an arrow; extended make/break drives up.
        send_key(8'h75, 1'b0, 1'b0);
        chk_dirs("plain75_no_up", 5'b00000);
        send_key(8'h75, 1'b1, 1'b0);
        chk_dirs("e0_75_up", 5'b10000);
        chk("e0_75_ext", 32'({keys.key_ext, keys.key_code}), 32'h175);
        send_key(8'h75, 1'b1, 1'b1);
        chk_dirs("e0f0_75_up_off", 5'b00000);
        chk("e0f0_75_break", 32'(keys.key_break), 32'd1);

        // Opposite directions together, typematic repeat, selective release.
        send_key(8'h6B, 1'b1, 1'b0);
        send_key(8'h74, 1'b1, 1'b0);
        chk_dirs("left_right_both", 5'b00110);
        send_key(8'h74, 1'b1, 1'b0);
        chk_dirs("typematic_right", 5'b00110);
        send_key(8'h6B, 1'b1, 1'b1);
        chk_dirs("left_released", 5'b00010);
        send_key(8'h72, 1'b1, 1'b1);
        chk_dirs("break_never_pressed", 5'b00010);

        // Parity error: no key event, enter unchanged; then a good 5A.
        push_ev(1'b1, 8'h00, 1'b0, 1'b0);
        send_byte(8'h5A, 1'b1);
        chk_dirs("bad_parity_no_enter", 5'b00010);
        send_key(8'h5A, 1'b0, 1'b0);
        chk_dirs("enter_on", 5'b00011);

        // A frame error discards a pending E0 prefix.
        send_byte(8'hE0, 1'b0);
        push_ev(1'b1, 8'h00, 1'b0, 1'b0);
        send_byte(8'h33, 1'b1);
        push_ev(1'b0, 8'h75, 1'b0, 1'b0);
        send_byte(8'h75, 1'b0);
        chk_dirs("prefix_cleared_by_err", 5'b00011);

        // Start bit of 1 while idle.
        push_ev(1'b1, 8'h00, 1'b0, 1'b0);
        ps2_bit(1'b1);
        repeat (HALF) @(posedge clk);
        chk_dirs("start_err_levels", 5'b00011);

        // Timeout: start + 4 data bits, then silence.
        push_ev(1'b1, 8'h00, 1'b0, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        got     = 1'b0;
        err_cyc = 0;
        for (int i = 0; i < 60000; i++) begin
            @(negedge clk);
            if (!got && keys.frame_err) begin
                got     = 1'b1;
                err_cyc = cyc;
            end
        end
        chk("timeout_seen", 32'(got), 32'd1);
        d = err_cyc - last_fall;
        chk("timeout_latency_window",
            32'((d >= int'(TIMEOUT_CYCLES)) && (d <= int'(TIMEOUT_CYCLES) + 12)), 32'd1);
        send_key(8'h72, 1'b1, 1'b0);
        chk_dirs("down_after_timeout", 5'b01011);

        // Reset mid-frame after an E0 prefix.
        send_byte(8'hE0, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0);
        ps2_data = 1'b1;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_mid_frame", 32'({keys.up, keys.down, keys.left, keys.right, keys.enter,
                                    keys.key_valid, keys.key_code, keys.key_ext,
                                    keys.key_break, keys.frame_err}), 32'd0);
        @(posedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        send_key(8'h72, 1'b0, 1'b0);
        chk_dirs("plain72_no_down", 5'b00000);
        chk("plain72_not_ext", 32'({keys.key_ext, keys.key_code}), 32'h072);

`ifdef PS2_WASD_EN
        send_key(8'h1D, 1'b0, 1'b0);
        chk_dirs("wasd_w_up", 5'b10000);
        send_key(8'h75, 1'b1, 1'b0);
        send_key(8'h75, 1'b1, 1'b1);
        chk_dirs("wasd_holds_up", 5'b10000);
        send_key(8'h1D, 1'b0, 1'b1);
        chk_dirs("wasd_w_release", 5'b00000);
`else
        send_key(8'h1D, 1'b0, 1'b0);
        chk_dirs("no_wasd_1d", 5'b00000);
        chk("no_wasd_code", 32'(keys.key_code), 32'h1D);
`endif

        repeat (20) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_dir_keys.md
# ps2_dir_keys

PS/2 keyboard receiver and key decoder that turns raw `ps2_clk`/`ps2_data` pin activity into held-level direction and enter controls for the player movement stage. It sits between the keyboard pins and `player_move`, and runs on the 25 MHz game clock. Frames are checked for start, parity and stop bits, and are aborted on timeout. The block tracks E0 (extended) and F0 (break) prefixes, so each output stays high exactly while its key is held.

## Interface
- `FILTER_LEN`, 4: consecutive stable samples required to accept a `ps2_clk` level change.
- `TIMEOUT_CYCLES`, 50000: clk cycles without a recognized falling edge before an in-progress frame is aborted (2 ms at 25 MHz).
- `clk`  in  1  25 MHz system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `ps2_clk`  in  1  raw keyboard clock pin (asynchronous).
- `ps2_data`  in  1  raw keyboard data pin (asynchronous).
- `up`, `down`, `left`, `right`  out  1  each  held level, 1 while the key is pressed.
- `enter`  out  1  held level for Enter.
- `key_valid`  out  1  one-cycle pulse per decoded non-prefix scan code.
- `key_code`  out  8  last decoded scan code; held between pulses.
- `key_ext`  out  1  E0 prefix preceded `key_code`.
- `key_break`  out  1  F0 prefix preceded `key_code`.
- `frame_err`  out  1  one-cycle pulse on a parity, start or stop error, or on a timeout.

## Operation
- Input conditioning:
  - Both pins pass through 2-FF synchronizers.
  - The filter holds a stable `ps2_clk` level. The level changes only after the synchronized value differs from it for `FILTER_LEN` consecutive cycles.
  - A 1->0 change of the filtered level produces a one-cycle `fall` strobe. Synchronized `ps2_data` is sampled on that cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall`, if the sampled bit is 0, go to DATA with bit count 0. If the sampled bit is 1, pulse `frame_err` and stay in IDLE.
  - DATA: on `fall`, shift the bit in LSB-first. After 8 bits, go to PARITY.
  - PARITY: on `fall`, capture the parity bit and go to STOP.
  - STOP: on `fall`, the frame is good if the stop bit is 1 and the data+parity ones-count is odd. Otherwise pulse `frame_err`. Go to IDLE either way.
  - Timeout: the counter counts while not in IDLE and clears on every `fall`. On reaching `TIMEOUT_CYCLES`, go to IDLE and pulse `frame_err`.
- Decoder runs on each good byte:
  - E0 sets `ext_f`. F0 sets `brk_f`. Neither pulses `key_valid`.
  - Any other byte:
    - Pulse `key_valid` with `key_code`/`key_ext`/`key_break` equal to the byte and the prefix flags.
    - Apply the level update.
    - Clear `ext_f` and `brk_f`.
- Level update (value = !`brk_f`):
  - Extended 75 -> `up`, 72 -> `down`, 6B -> `left`, 74 -> `right`.
  - Non-extended 5A -> `enter`.
  - Other codes change no level.
- `frame_err` clears `ext_f` and `brk_f`, so a corrupted prefix never attaches to a later byte.
- Opposite directions may be high simultaneously. No priority is applied here.
- A break for a key never pressed leaves its level at 0.
- Typematic repeats of a make code re-pulse `key_valid`. The level stays 1.

## Timing
- Reset (async assert):
  - FSM goes to IDLE; counters, flags and shift register clear.
  - All outputs are 0, including `key_code` = 8'h00.
  - Filtered clock level resets to 1.
- Reset mid-frame discards the partial byte. The first `fall` after release must be a start bit.
- The `fall` strobe lags the raw pin fall by 2 + `FILTER_LEN` cycles, ±1.
- Level outputs, `key_valid` and `frame_err` assert on the clock edge after the stop-bit (or error) `fall` cycle.
- Total latency from raw stop-bit fall to output is at most `FILTER_LEN` + 4 cycles.
- `key_valid` and `frame_err` are never high in the same cycle.
- Pulses are exactly 1 cycle wide.

## Configuration
- `PS2_WASD_EN` defined: non-extended 1D -> `up`, 1B -> `down`, 1C -> `left`, 23 -> `right`. These are ORed with the arrow-key states; each key source keeps its own held bit.
- Not defined: only arrow keys drive directions, and 1D/1B/1C/23 only pulse `key_valid`.

## Test plan
- Send frame 75 (parity 0), then E0 75 -> `key_valid` pulse with `key_ext`=1, `key_code`=75, `up`=1. Then send E0 F0 75 -> `up`=0, `key_break`=1.
- Send E0 6B and E0 74 back-to-back -> `left`=1 and `right`=1 together. Then send E0 F0 6B -> `left`=0, `right` stays 1.
- Send 5A with parity forced to 0 -> `frame_err` pulse, `enter` stays 0, no `key_valid`. Next a valid 5A -> `enter`=1.
- Send start bit + 4 data bits, then idle for 60000 cycles -> `frame_err` at 50000 cycles after the last fall. A following E0 72 -> `down`=1.
- Send E0, then assert `rst_n`=0 mid-frame of 72 and release -> all outputs 0. A full 72 afterward is non-extended -> `key_valid`, `down` stays 0.
- With `PS2_WASD_EN`: send 1D -> `up`=1. Send E0 75, then E0 F0 75 -> `up` remains 1. Send F0 1D -> `up`=0.
